// File: rtl/frame_symbol_tx.sv
// frame_symbol_tx: serialises payload bytes into framed 2-bit line symbols.
// Optional per-byte even-parity symbol when FRAME_TX_PARITY_EN is defined.
module frame_symbol_tx #(
  parameter int MAX_BYTES = 16,
  parameter int GAP_SYMS  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] g,
  output logic       busy,
  output logic       underrun
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0] MAXB = CW'(MAX_BYTES);
  localparam logic [3:0] GAP_LAST = 4'(GAP_SYMS - 1);
`ifdef FRAME_TX_PARITY_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_POST,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [3:0]    r_ph;
  logic [7:0]    r_shift;
  logic          r_cur_last;
  logic [7:0]    r_hold;
  logic          r_hold_full;
  logic          r_hold_last;
  logic [CW-1:0] r_cnt;
  logic          r_cut;
  logic [1:0]    r_g;
  logic          r_busy;
  logic          r_under;

  logic          w_room;
  logic          w_ready;
  logic          w_accept;
  logic [CW-1:0] w_cnt_inc;
  logic          w_acc_last;
  logic [1:0]    w_sym;

  // Handshake qualification; a byte counts as last when flagged or when it fills the frame.
  always_comb begin
    w_room     = !r_hold_full && !r_cur_last && (r_cnt < MAXB);
    w_ready    = reset &&
                 ((r_state == S_IDLE) || ((r_state == S_DATA) && w_room));
    w_accept   = in_valid && w_ready;
    w_cnt_inc  = r_cnt + 1'b1;
    w_acc_last = in_last || (w_cnt_inc == MAXB);
  end

  // Symbol for the current state/phase; registered into g on the next edge.
  always_comb begin
    w_sym = 2'b00;
    unique case (r_state)
      S_PRE:   w_sym = (r_ph == 4'd0) ? 2'b01 : 2'b00;
      S_DATA:  w_sym = {1'b0, r_shift[r_ph[2:0]]};
      S_POST:  w_sym = ((r_ph == 4'd0) || (r_ph == 4'd3)) ? 2'b11 : 2'b00;
      default: w_sym = 2'b00;
    endcase
`ifdef FRAME_TX_PARITY_EN
    if ((r_state == S_DATA) && (r_ph == 4'd8))
      w_sym = {1'b0, ^r_shift};
`endif
  end

  // Framing FSM with registered line symbol, busy and underrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ph        <= 4'd0;
      r_shift     <= 8'd0;
      r_cur_last  <= 1'b0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_cnt       <= '0;
      r_cut       <= 1'b0;
      r_g         <= 2'b00;
      r_busy      <= 1'b0;
      r_under     <= 1'b0;
    end else begin
      r_g     <= w_sym;
      r_under <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift    <= in_data;
            r_cur_last <= w_acc_last;
            r_cnt      <= w_cnt_inc;
            r_ph       <= 4'd0;
            r_state    <= S_PRE;
            r_busy     <= 1'b1;
          end
        end
        S_PRE: begin
          if (r_ph == 4'd3) begin
            r_ph    <= 4'd0;
            r_state <= S_DATA;
          end else begin
            r_ph <= r_ph + 4'd1;
          end
        end
        S_DATA: begin
          if (r_ph == LAST_IDX) begin
            r_ph <= 4'd0;
            if (r_cur_last) begin
              r_state <= S_POST;
              r_cut   <= 1'b0;
            end else if (r_hold_full) begin
              r_shift     <= r_hold;
              r_cur_last  <= r_hold_last;
              r_hold_full <= 1'b0;
            end else if (w_accept) begin
              r_shift    <= in_data;
              r_cur_last <= w_acc_last;
              r_cnt      <= w_cnt_inc;
            end else begin
              r_state <= S_POST;
              r_cut   <= 1'b1;
            end
          end else begin
            r_ph <= r_ph + 4'd1;
            if (w_accept) begin
              r_hold      <= in_data;
              r_hold_full <= 1'b1;
              r_hold_last <= w_acc_last;
              r_cnt       <= w_cnt_inc;
            end
          end
        end
        S_POST: begin
          if (r_ph == 4'd0)
            r_under <= r_cut;
          if (r_ph == 4'd3) begin
            r_ph        <= 4'd0;
            r_state     <= S_GAP;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
            r_hold_last <= 1'b0;
            r_cur_last  <= 1'b0;
            r_cut       <= 1'b0;
          end else begin
            r_ph <= r_ph + 4'd1;
          end
        end
        S_GAP: begin
          if (r_ph == GAP_LAST) begin
            r_ph    <= 4'd0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ph <= r_ph + 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = w_ready;
  assign g        = r_g;
  assign busy     = r_busy;
  assign underrun = r_under;

endmodule
